fir_tap_adder_tree: RTL

Pipelined, valid-tracked adder tree that reduces the ORD signed tap products of the log-domain FIR tap array to a single filter output sample. It sits directly downstream of the tap multiplier array and consumes its packed tap output bus. It carries full precision through the tree, saturates the root sum to WIDTH bits, and presents a registered output with a valid strobe to the error/weight-update stage.

---
 rtl/fir_tap_adder_tree.sv | 102 ++++++++++
 1 files changed

// File: rtl/fir_tap_adder_tree.sv
// Pipelined adder tree that reduces ORD signed tap products to one filter sample.
// The output is saturated to WIDTH bits, and a valid strobe travels alongside the data.
module fir_tap_adder_tree #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned QP    = 12,
  parameter  int unsigned ORD   = 64,
  localparam int unsigned S     = $clog2(ORD)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ORD*WIDTH-1:0]      tap_in_packed,
  input  logic                      tap_in_valid,
  output logic signed [WIDTH-1:0]   sum_out,
  output logic signed [WIDTH+S-1:0] sum_full,
  output logic                      sum_valid,
  output logic                      sum_sat
);

  localparam int unsigned RW = WIDTH + S;
  localparam logic signed [RW-1:0] SAT_HI = RW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
  localparam logic signed [RW-1:0] SAT_LO = RW'(-(64'sd1 <<< (WIDTH - 1)));

  if ((ORD < 2) || ((ORD & (ORD - 1)) != 0) || (QP > WIDTH)) begin : g_param_check
    $error("fir_tap_adder_tree: ORD must be a power of two >= 2 and QP <= WIDTH");
  end

  logic [ORD*WIDTH-1:0] tap_q;
  logic [S:0]           vld;

  // Input capture; bit k of vld enables tree stage k+1, bit S enables the output stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_q <= '0;
      vld   <= '0;
    end else begin
      if (tap_in_valid) tap_q <= tap_in_packed;
      vld <= {vld[S-1:0], tap_in_valid};
    end
  end

  for (genvar k = 1; k <= S; k++) begin : g_stage
    localparam int unsigned N = ORD >> k;
    localparam int unsigned W = WIDTH + k;

    logic signed [W-1:0] node       [N];
    logic signed [W-1:0] pair_sum_c [N];

    for (genvar j = 0; j < N; j++) begin : g_pair
      if (k == 1) begin : g_leaf
        assign pair_sum_c[j] = W'($signed(tap_q[WIDTH*(2*j)   +: WIDTH]))
                             + W'($signed(tap_q[WIDTH*(2*j+1) +: WIDTH]));
      end else begin : g_inner
        assign pair_sum_c[j] = W'(g_stage[k-1].node[2*j])
                             + W'(g_stage[k-1].node[2*j+1]);
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int j = 0; j < int'(N); j++) node[j] <= '0;
      end else if (vld[k-1]) begin
        for (int j = 0; j < int'(N); j++) node[j] <= pair_sum_c[j];
      end
    end
  end

  logic signed [RW-1:0]    root;
  logic signed [WIDTH-1:0] sat_val_c;
  logic                    sat_flag_c;

  assign root = g_stage[S].node[0];

  // Clamp the full-precision root to the WIDTH-bit signed range
  always_comb begin
    sat_val_c  = root[WIDTH-1:0];
    sat_flag_c = 1'b0;
    if (root > SAT_HI) begin
      sat_val_c  = {1'b0, {(WIDTH-1){1'b1}}};
      sat_flag_c = 1'b1;
    end else if (root < SAT_LO) begin
      sat_val_c  = {1'b1, {(WIDTH-1){1'b0}}};
      sat_flag_c = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_out   <= '0;
      sum_full  <= '0;
      sum_sat   <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= vld[S];
      if (vld[S]) begin
        sum_out  <= sat_val_c;
        sum_full <= root;
        sum_sat  <= sat_flag_c;
      end
    end
  end

endmodule
